// File: rtl/spin_run_sequencer.sv
// Sequences settle/anneal/readout runs then waits in final_run for the drain-complete pulse.
// Latency: busy one cycle after START edge; each run takes max(settle,1)+max(anneal,1)+1 cycles.
// Backpressure: SPIN_SEQ_PAUSE_EN adds seq_pause, which freezes SETTLE/ANNEAL; FINAL waits on readout_done.
module spin_run_sequencer #(
    parameter int MAX_ENTRIES = 200,
    parameter int ANNEAL_W    = 16
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic                conf_sys_ctrl_reg_RESET,
    input  logic                conf_sys_ctrl_reg_START,
    input  logic [7:0]          conf_reg_total_run_count,
    input  logic [7:0]          conf_reg_total_rerun_count,
    input  logic [ANNEAL_W-1:0] conf_reg_anneal_cycles,
    input  logic [7:0]          conf_reg_settle_cycles,
`ifdef SPIN_SEQ_PAUSE_EN
    input  logic                seq_pause,
`endif
    input  logic                readout_done,
    output logic                config_dig_spin_CCII_ena,
    output logic                config_dig_spin_read_out_ena,
    output logic                final_run,
    output logic [7:0]          run_idx,
    output logic                rerun_active,
    output logic                busy,
    output logic                done
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_ANNEAL, S_READOUT, S_FINAL, S_DONE
    } state_t;

    localparam logic [8:0] MAX_E = 9'(MAX_ENTRIES);

    state_t              state;
    logic                reset_q;
    logic                start_q;
    logic                rst_edge;
    logic                start_edge;
    logic                hold;
    logic [8:0]          sum_w;
    logic [7:0]          total_w;
    logic [7:0]          total_l;
    logic [7:0]          run_l;
    logic [ANNEAL_W-1:0] settle_last_l;
    logic [ANNEAL_W-1:0] anneal_last_l;
    logic [ANNEAL_W-1:0] cnt;

    assign rst_edge   = conf_sys_ctrl_reg_RESET & ~reset_q;
    assign start_edge = conf_sys_ctrl_reg_START & ~start_q;

`ifdef SPIN_SEQ_PAUSE_EN
    assign hold = seq_pause;
`else
    assign hold = 1'b0;
`endif

    // Sum is taken 9 bits wide so 255+255 cannot wrap below the clamp.
    assign sum_w   = {1'b0, conf_reg_total_run_count} + {1'b0, conf_reg_total_rerun_count};
    assign total_w = (sum_w > MAX_E) ? MAX_E[7:0] : sum_w[7:0];

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state                        <= S_IDLE;
            reset_q                      <= 1'b0;
            start_q                      <= 1'b0;
            total_l                      <= '0;
            run_l                        <= '0;
            settle_last_l                <= '0;
            anneal_last_l                <= '0;
            cnt                          <= '0;
            config_dig_spin_CCII_ena     <= 1'b0;
            config_dig_spin_read_out_ena <= 1'b0;
            final_run                    <= 1'b0;
            run_idx                      <= '0;
            rerun_active                 <= 1'b0;
            busy                         <= 1'b0;
            done                         <= 1'b0;
        end else begin
            reset_q <= conf_sys_ctrl_reg_RESET;
            start_q <= conf_sys_ctrl_reg_START;
            if (rst_edge) begin
                state                        <= S_IDLE;
                cnt                          <= '0;
                config_dig_spin_CCII_ena     <= 1'b0;
                config_dig_spin_read_out_ena <= 1'b0;
                final_run                    <= 1'b0;
                run_idx                      <= '0;
                rerun_active                 <= 1'b0;
                busy                         <= 1'b0;
                done                         <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (start_edge) begin
                            total_l       <= total_w;
                            run_l         <= conf_reg_total_run_count;
                            settle_last_l <= (conf_reg_settle_cycles == 8'd0) ? '0 :
                                             ANNEAL_W'(conf_reg_settle_cycles - 8'd1);
                            anneal_last_l <= (conf_reg_anneal_cycles == '0) ? '0 :
                                             conf_reg_anneal_cycles - ANNEAL_W'(1);
                            cnt           <= '0;
                            run_idx       <= '0;
                            if (total_w == 8'd0) begin
                                state        <= S_DONE;
                                done         <= 1'b1;
                                busy         <= 1'b0;
                                rerun_active <= 1'b0;
                            end else begin
                                state        <= S_SETTLE;
                                done         <= 1'b0;
                                busy         <= 1'b1;
                                rerun_active <= (conf_reg_total_run_count == 8'd0);
                            end
                        end
                    end
                    S_SETTLE: begin
                        if (!hold) begin
                            if (cnt == settle_last_l) begin
                                cnt                      <= '0;
                                state                    <= S_ANNEAL;
                                config_dig_spin_CCII_ena <= 1'b1;
                            end else begin
                                cnt <= cnt + ANNEAL_W'(1);
                            end
                        end
                    end
                    S_ANNEAL: begin
                        if (!hold) begin
                            if (cnt == anneal_last_l) begin
                                cnt                          <= '0;
                                state                        <= S_READOUT;
                                config_dig_spin_CCII_ena     <= 1'b0;
                                config_dig_spin_read_out_ena <= 1'b1;
                            end else begin
                                cnt <= cnt + ANNEAL_W'(1);
                            end
                        end
                    end
                    S_READOUT: begin
                        config_dig_spin_read_out_ena <= 1'b0;
                        if (run_idx == total_l - 8'd1) begin
                            state     <= S_FINAL;
                            final_run <= 1'b1;
                        end else begin
                            state        <= S_SETTLE;
                            run_idx      <= run_idx + 8'd1;
                            rerun_active <= (({1'b0, run_idx} + 9'd1) >= {1'b0, run_l});
                        end
                    end
                    S_FINAL: begin
                        if (readout_done) begin
                            state        <= S_DONE;
                            final_run    <= 1'b0;
                            done         <= 1'b1;
                            busy         <= 1'b0;
                            rerun_active <= 1'b0;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spin_run_sequencer.sv
// Directed bench for spin_run_sequencer; define SPIN_SEQ_PAUSE_EN to also exercise seq_pause.
module tb_spin_run_sequencer;

    logic        i_clk = 1'b0;
    logic        i_rstn = 1'b0;
    logic        soft_reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  run_cnt = '0;
    logic [7:0]  rerun_cnt = '0;
    logic [15:0] anneal_cyc = '0;
    logic [7:0]  settle_cyc = '0;
    logic        readout_done = 1'b0;
`ifdef SPIN_SEQ_PAUSE_EN
    logic        seq_pause = 1'b0;
`endif
    logic        ccii_ena;
    logic        rdo_ena;
    logic        final_run;
    logic [7:0]  run_idx;
    logic        rerun_active;
    logic        busy;
    logic        done;

    int n_chk = 0;
    int n_pass = 0;
    int np;
    int ccii_cnt;
    int fin_k;
    int last_k;
    int bad;
    int stray;
    int pulse_k [3];

    spin_run_sequencer #(.MAX_ENTRIES(200), .ANNEAL_W(16)) dut (
        .i_clk                        (i_clk),
        .i_rstn                       (i_rstn),
        .conf_sys_ctrl_reg_RESET      (soft_reset),
        .conf_sys_ctrl_reg_START      (start),
        .conf_reg_total_run_count     (run_cnt),
        .conf_reg_total_rerun_count   (rerun_cnt),
        .conf_reg_anneal_cycles       (anneal_cyc),
        .conf_reg_settle_cycles       (settle_cyc),
`ifdef SPIN_SEQ_PAUSE_EN
        .seq_pause                    (seq_pause),
`endif
        .readout_done                 (readout_done),
        .config_dig_spin_CCII_ena     (ccii_ena),
        .config_dig_spin_read_out_ena (rdo_ena),
        .final_run                    (final_run),
        .run_idx                      (run_idx),
        .rerun_active                 (rerun_active),
        .busy                         (busy),
        .done                         (done)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge i_clk);
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {25'd0, ccii_ena, rdo_ena, final_run, rerun_active, busy, done, |run_idx}, 32'd0);
    endtask

    initial begin
        // Async reset state
        repeat (2) tick();
        check_all_zero("reset_outputs");
        i_rstn = 1'b1;
        tick();

        // Test 1: run=2 rerun=1 settle=2 anneal=4
        run_cnt = 8'd2; rerun_cnt = 8'd1; settle_cyc = 8'd2; anneal_cyc = 16'd4;
        start = 1'b1;
        np = 0; ccii_cnt = 0; fin_k = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 1) begin
                check("t1_busy_rise", {31'd0, busy}, 32'd1);
                // Mid-sequence config changes must not take effect
                settle_cyc = 8'd9; anneal_cyc = 16'd20; run_cnt = 8'd0;
            end
            ccii_cnt += int'(ccii_ena);
            if (rdo_ena) begin
                if (np < 3) pulse_k[np] = k;
                check("t1_pulse_run_idx", {24'd0, run_idx}, np);
                check("t1_pulse_rerun", {31'd0, rerun_active}, (np == 2) ? 32'd1 : 32'd0);
                np++;
            end
            if (final_run) begin
                fin_k = k;
                break;
            end
        end
        check("t1_pulse_count", np, 3);
        check("t1_ccii_cycles", ccii_cnt, 12);
        check("t1_pulse0_cycle", pulse_k[0], 7);
        check("t1_pulse1_cycle", pulse_k[1], 14);
        check("t1_pulse2_cycle", pulse_k[2], 21);
        check("t1_final_cycle", fin_k, 22);
        check("t1_final_run_idx", {24'd0, run_idx}, 2);

        // Test 5: FINAL waits for readout_done, then DONE; START restarts
        tick(); tick();
        check("t5_final_hold", {30'd0, final_run, done}, 32'd2);
        readout_done = 1'b1;
        tick();
        readout_done = 1'b0;
        check("t5_done_flags", {29'd0, done, final_run, busy}, 32'd4);
        tick();
        check("t5_done_held", {31'd0, done}, 32'd1);
        run_cnt = 8'd2; rerun_cnt = 8'd1; settle_cyc = 8'd2; anneal_cyc = 16'd4;
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        check("t5_restart", {30'd0, done, busy}, 32'd1);
        soft_reset = 1'b1;
        tick();
        check_all_zero("t5_abort_zero");
        soft_reset = 1'b0; start = 1'b0;
        tick();

        // Test 3: soft reset during third anneal cycle of run 1
        start = 1'b1;
        for (int k = 1; k <= 12; k++) tick();
        check("t3_pre_reset", {23'd0, ccii_ena, run_idx}, 32'h101);
        soft_reset = 1'b1;
        tick();
        check_all_zero("t3_reset_zero");
        soft_reset = 1'b0; start = 1'b0;
        tick();
        start = 1'b1;
        for (int k = 1; k <= 7; k++) tick();
        check("t3_restart_pulse", {23'd0, rdo_ena, run_idx}, 32'h100);
        soft_reset = 1'b1;
        tick();
        soft_reset = 1'b0; start = 1'b0;
        tick();

        // Test 2: zero runs go straight to DONE
        run_cnt = 8'd0; rerun_cnt = 8'd0;
        start = 1'b1;
        tick();
        check("t2_done_now", {30'd0, done, busy}, 32'd2);
        stray = 0;
        for (int k = 1; k <= 10; k++) begin
            readout_done = (k == 3);
            tick();
            stray += int'(ccii_ena | rdo_ena | final_run | busy);
        end
        readout_done = 1'b0;
        check("t2_no_activity", stray, 0);
        check("t2_done_held", {31'd0, done}, 32'd1);

        // Test 4: 150+100 clamps to 200 runs, 3 cycles each
        start = 1'b0;
        run_cnt = 8'd150; rerun_cnt = 8'd100; settle_cyc = 8'd0; anneal_cyc = 16'd1;
        tick();
        start = 1'b1;
        np = 0; bad = 0; last_k = 0; fin_k = 0;
        for (int k = 1; k <= 1000; k++) begin
            tick();
            if (k == 100) start = 1'b0;
            if (k == 101) start = 1'b1;
            if (rdo_ena) begin
                if (np == 0 && k != 3) bad++;
                if (np > 0 && k - last_k != 3) bad++;
                last_k = k;
                np++;
            end
            if (final_run) begin
                fin_k = k;
                break;
            end
        end
        check("t4_pulse_count", np, 200);
        check("t4_spacing_errors", bad, 0);
        check("t4_final_cycle", fin_k, 601);
        check("t4_final_idx_rerun", {23'd0, rerun_active, run_idx}, 32'h1C7);
        readout_done = 1'b1;
        tick();
        readout_done = 1'b0;
        check("t4_done", {30'd0, done, final_run}, 32'd2);

`ifdef SPIN_SEQ_PAUSE_EN
        // Test 6: five paused cycles mid-anneal stretch CCII to 13 cycles
        start = 1'b0;
        run_cnt = 8'd1; rerun_cnt = 8'd0; settle_cyc = 8'd2; anneal_cyc = 16'd8;
        tick();
        start = 1'b1;
        ccii_cnt = 0; fin_k = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            ccii_cnt += int'(ccii_ena);
            if (k == 5) seq_pause = 1'b1;
            if (k == 10) seq_pause = 1'b0;
            if (final_run) begin
                fin_k = k;
                break;
            end
        end
        check("t6_ccii_cycles", ccii_cnt, 13);
        check("t6_final_cycle", fin_k, 17);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
